pipeline_if_fetch5: RTL

Fetch stage of the 5-stage pipeline and the consumer end of the branch redirect that the execution-branch stage produces.
- Owns the fetch PC and talks to instruction memory through a request/response interface with one outstanding request.
- Presents pc/instruction pairs to the decode-side pipeline register.
- Applies branch_taken/branch_target redirects, squashing stale in-flight fetches.
- Honours hazard-unit stall by buffering a returning instruction.

---
 rtl/if_pkg.sv | 31 +++
 rtl/if_hold_buf.sv | 42 ++++
 rtl/pipeline_if_fetch5.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/if_pkg.sv
// ============================================================================
// Module   : if_pkg
// Purpose  : Shared types and constants for the pipeline instruction-fetch stage.
// Revision : 1.0
// ============================================================================
`default_nettype none

package if_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2,
        S_HOLD = 2'd3
    } if_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
    } fetch_pkt_t;

    // The sum is 64 bits wide, so the carry out of bit 63 is dropped.
    function automatic logic [63:0] pc_advance(input logic [63:0] pc, input logic [63:0] step);
        return pc + step;
    endfunction

endpackage

`default_nettype wire

// File: rtl/if_hold_buf.sv
// ============================================================================
// Module   : if_hold_buf
// Purpose  : Single-entry pc/instruction buffer. It catches a response that
//            returns while the pipeline is stalled.
// Revision : 1.0
// ============================================================================
`default_nettype none

module if_hold_buf
    import if_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       load_i,
    input  logic       clear_i,
    input  fetch_pkt_t pkt_i,
    output fetch_pkt_t pkt_o,
    output logic       valid_o
);

    fetch_pkt_t pkt_q;
    logic       valid_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pkt_q   <= '0;
            valid_q <= 1'b0;
        end else if (clear_i) begin
            pkt_q   <= '0;
            valid_q <= 1'b0;
        end else if (load_i) begin
            pkt_q   <= pkt_i;
            valid_q <= 1'b1;
        end
    end

    assign pkt_o   = pkt_q;
    assign valid_o = valid_q;

endmodule

`default_nettype wire

// File: rtl/pipeline_if_fetch5.sv
// ============================================================================
// Module   : pipeline_if_fetch5
// Purpose  : IF stage of the 5-stage pipeline. It supports one outstanding
//            imem request and applies branch redirects and stalls.
//            Optional macro IF_MISALIGN_TRAP_EN adds the misalign_IF trap output.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pipeline_if_fetch5
    import if_pkg::*;
#(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000,
    parameter logic [63:0] PC_STEP  = 64'd4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken_EXB,
    input  logic [63:0] branch_target_EXB,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [63:0] pc_IF,
    output logic [31:0] instr_IF,
    output logic        valid_IF,
    output logic        flush_IF
`ifdef IF_MISALIGN_TRAP_EN
   ,output logic        misalign_IF
`endif
);

    if_state_t   state_q, state_d;
    logic [63:0] fetch_pc_q, fetch_pc_d;
    logic [63:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic        valid_q, valid_d;

    logic        w_redirect;
    logic [63:0] w_target;
    logic        w_block;
    logic [63:0] w_pc_next;
    logic        w_idle_issue;
    logic        w_rsp_accept;
    logic        w_hold_load;
    logic        w_hold_present;
    logic        w_hold_clear;
    logic        w_hold_valid;
    fetch_pkt_t  w_hold_in;
    fetch_pkt_t  w_hold_pkt;

    assign w_redirect = branch_taken_EXB;
    assign w_pc_next  = pc_advance(fetch_pc_q, PC_STEP);

`ifdef IF_MISALIGN_TRAP_EN
    logic misalign_q, misalign_d;
    logic w_misaligned;

    assign w_target     = branch_target_EXB;
    assign w_misaligned = |branch_target_EXB[1:0];
    assign w_block      = misalign_q;
    assign misalign_IF  = misalign_q;
`else
    assign w_target = branch_target_EXB & ~64'h3;
    assign w_block  = 1'b0;
`endif

    assign w_idle_issue   = (state_q == S_IDLE) & ~stall & ~w_redirect & ~w_block;
    assign w_rsp_accept   = (state_q == S_WAIT) & imem_rvalid & ~w_redirect & ~stall;
    assign w_hold_load    = (state_q == S_WAIT) & imem_rvalid & ~w_redirect & stall;
    assign w_hold_present = (state_q == S_HOLD) & w_hold_valid & ~w_redirect & ~stall;
    assign w_hold_clear   = (state_q == S_HOLD) & (w_redirect | ~stall);

    // The accepted-response path reissues in the same cycle so a 1-cycle memory streams.
    assign imem_req  = reset & (w_idle_issue | w_rsp_accept);
    assign imem_addr = w_rsp_accept ? w_pc_next : fetch_pc_q;
    assign flush_IF  = branch_taken_EXB;

    assign w_hold_in.pc    = fetch_pc_q;
    assign w_hold_in.instr = imem_rdata;

    if_hold_buf u_hold_buf (
        .clk     (clk),
        .reset   (reset),
        .load_i  (w_hold_load),
        .clear_i (w_hold_clear),
        .pkt_i   (w_hold_in),
        .pkt_o   (w_hold_pkt),
        .valid_o (w_hold_valid)
    );

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        valid_d    = valid_q;
`ifdef IF_MISALIGN_TRAP_EN
        misalign_d = misalign_q;
`endif
        if (w_redirect) begin
            fetch_pc_d = w_target;
            pc_d       = '0;
            instr_d    = NOP_INSTR;
            valid_d    = 1'b0;
            // An in-flight request whose response has not arrived must still be drained.
            if (((state_q == S_WAIT) || (state_q == S_DROP)) && !imem_rvalid)
                state_d = S_DROP;
            else
                state_d = S_IDLE;
`ifdef IF_MISALIGN_TRAP_EN
            misalign_d = w_misaligned;
            if (w_misaligned)
                pc_d = branch_target_EXB;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (w_idle_issue)
                        state_d = S_WAIT;
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        if (stall)
                            state_d = S_HOLD;
                        else
                            fetch_pc_d = w_pc_next;
                    end
                end
                S_DROP: begin
                    if (imem_rvalid)
                        state_d = S_IDLE;
                end
                S_HOLD: begin
                    if (w_hold_present) begin
                        state_d    = S_IDLE;
                        fetch_pc_d = w_pc_next;
                    end
                end
                default: state_d = S_IDLE;
            endcase

            if (!stall) begin
                if (w_rsp_accept) begin
                    pc_d    = fetch_pc_q;
                    instr_d = imem_rdata;
                    valid_d = 1'b1;
                end else if (w_hold_present) begin
                    pc_d    = w_hold_pkt.pc;
                    instr_d = w_hold_pkt.instr;
                    valid_d = 1'b1;
                end else begin
                    valid_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            fetch_pc_q <= RESET_PC;
            pc_q       <= '0;
            instr_q    <= NOP_INSTR;
            valid_q    <= 1'b0;
`ifdef IF_MISALIGN_TRAP_EN
            misalign_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            valid_q    <= valid_d;
`ifdef IF_MISALIGN_TRAP_EN
            misalign_q <= misalign_d;
`endif
        end
    end

    assign pc_IF    = pc_q;
    assign instr_IF = instr_q;
    assign valid_IF = valid_q;

endmodule

`default_nettype wire
